// File: rtl/wb_collect_pkg.sv
// Shared types for the FU result interface and the squash-order helper.
// younger() is the single definition of "issued after the redirect point",
// so the FUs and the writeback collector can never disagree on what to drop.
package wb_collect_pkg;

  typedef struct packed {
    logic [15:0] opid;   // [15] = valid
    logic [31:0] data;
  } exe_bundle_t;

  typedef struct packed {
    logic [15:0] opid;   // redirecting op; [15] = redirect valid
    logic [15:0] topid;  // oldest op in flight, origin of the order arithmetic
  } red_bundle_t;

  // Index width helper that never returns zero (single-entry vectors).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // True when opid was issued after redir.opid. Distances are taken from
  // topid modulo the opid space so wrap-around of the id counter is harmless.
  function automatic logic younger(input red_bundle_t redir, input logic [15:0] opid,
                                   input int opsz);
    logic [15:0] d_id;
    logic [15:0] d_red;
    int          m_id;
    int          m_red;
    d_id  = opid - redir.topid;
    d_red = redir.opid - redir.topid;
    m_id  = int'(d_id) % opsz;
    m_red = int'(d_red) % opsz;
    return redir.opid[15] & opid[15] & (m_id >= m_red + 1);
  endfunction

endpackage

// File: rtl/wb_collect_rr_select.sv
// Round-robin lane selector for the writeback collector.
// Scans units starting at rr; inside a unit lanes go 0..ewd-1 and the scan of
// that unit stops at the first invalid lane or the first lane that cannot get a
// slot, so per-unit claims are always a prefix from lane 0. Squashed lanes are
// claimed without consuming a slot.
// Ports:
//   req_vld  in   [nfu*ewd]        lane valid, index = unit*ewd + lane
//   req_sq   in   [nfu*ewd]        lane is younger than an active redirect
//   rr       in   [rrw]            unit with first priority
//   en       in   1                writeback can accept (gates all claims)
//   claim    out  [nfu*ewd]        lane retired this cycle
//   take     out  [nfu*ewd]        lane claimed and placed in a wb slot
//   slot     out  [nfu*ewd][sw]    wb slot of each taken lane
//   any_take out  1                at least one lane got a slot
//   rr_next  out  [rrw]            rr for the next cycle when any_take
module wb_collect_rr_select
  import wb_collect_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 2,
  parameter int wbw = 2,
  parameter int nl  = nfu * ewd,
  parameter int iw  = idx_w(nfu * ewd),
  parameter int sw  = idx_w(wbw),
  parameter int rrw = idx_w(nfu)
) (
  input  logic [nl-1:0]         req_vld,
  input  logic [nl-1:0]         req_sq,
  input  logic [rrw-1:0]        rr,
  input  logic                  en,
  output logic [nl-1:0]         claim,
  output logic [nl-1:0]         take,
  output logic [nl-1:0][sw-1:0] slot,
  output logic                  any_take,
  output logic [rrw-1:0]        rr_next
);

  int          used;
  int          last_u;
  int          start;
  logic        cut;
  logic        open;
  logic [iw-1:0] ix;

  always_comb begin
    claim    = '0;
    take     = '0;
    slot     = '0;
    any_take = 1'b0;
    rr_next  = rr;
    used     = 0;
    last_u   = 0;
    cut      = 1'b0;
    open     = 1'b0;
    ix       = '0;
    start    = int'(rr);
    for (int k = 0; k < nfu; k++) begin
      // Unrolled match on the rotated unit keeps every select index constant.
      for (int u = 0; u < nfu; u++) begin
        if (u == (start + k) % nfu) begin
          open = 1'b1;
          for (int l = 0; l < ewd; l++) begin
            ix = iw'(u * ewd + l);
            if (open && req_vld[ix]) begin
              if (req_sq[ix]) begin
                claim[ix] = 1'b1;
              end else if (used < wbw) begin
                claim[ix] = 1'b1;
                take[ix]  = 1'b1;
                slot[ix]  = sw'(used);
                used      = used + 1;
                any_take  = 1'b1;
                last_u    = u;
                cut       = 1'b0;
              end else begin
                open = 1'b0;
                // The last contributor still has work behind its taken lanes:
                // it keeps first priority so its results stay in order.
                if (any_take && last_u == u) cut = 1'b1;
              end
            end else begin
              open = 1'b0;
            end
          end
        end
      end
    end
    if (any_take) rr_next = rrw'(cut ? last_u : (last_u + 1) % nfu);
    if (!en) begin
      claim    = '0;
      take     = '0;
      any_take = 1'b0;
      rr_next  = rr;
    end
  end

endmodule

// File: rtl/wb_collect.sv
// Writeback collector: consumer end of the FU result interface.
// Claims up to wbw non-squashed results per cycle from nfu units (round-robin
// fair), drains squashed results without using slots, and registers the chosen
// results compacted into wb[0..k-1]. Held wb entries are squashed in place
// while the writeback stage stalls.
// Ports:
//   clk       in   1                    clock
//   rst       in   1                    synchronous active-high reset
//   redir     in   red_bundle_t         redirect; opid[15] = valid
//   fu_resp   in   [nfu][ewd] bundles   FU results; lane valid = opid[15]
//   fu_claim  out  [nfu][ewd]           FU retires that lane at next edge
//   wb_ready  in   1                    writeback stage accepts wb this cycle
//   wb        out  [wbw] bundles        registered results; valid = opid[15]
module wb_collect
  import wb_collect_pkg::*;
#(
  parameter int nfu  = 4,
  parameter int ewd  = 2,
  parameter int wbw  = 2,
  parameter int opsz = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  red_bundle_t                      redir,
  input  exe_bundle_t [nfu-1:0][ewd-1:0]   fu_resp,
  output logic        [nfu-1:0][ewd-1:0]   fu_claim,
  input  logic                             wb_ready,
  output exe_bundle_t [wbw-1:0]            wb
);

  localparam int nl  = nfu * ewd;
  localparam int iw  = idx_w(nl);
  localparam int sw  = idx_w(wbw);
  localparam int rrw = idx_w(nfu);

  exe_bundle_t [nl-1:0]   lane_flat;
  logic [nl-1:0]          req_vld;
  logic [nl-1:0]          req_sq;
  logic [nl-1:0]          claim;
  logic [nl-1:0]          take;
  logic [nl-1:0][sw-1:0]  slot;
  logic                   any_take;
  logic [rrw-1:0]         rr_q, rr_d, rr_next;
  exe_bundle_t [wbw-1:0]  wb_q, wb_d;
  logic [iw-1:0]          ix;
  logic [sw-1:0]          sx;

  for (genvar gu = 0; gu < nfu; gu++) begin : g_unit
    for (genvar gl = 0; gl < ewd; gl++) begin : g_lane
      localparam int li = gu * ewd + gl;
      assign lane_flat[li]    = fu_resp[gu][gl];
      assign req_vld[li]      = fu_resp[gu][gl].opid[15];
      assign req_sq[li]       = younger(redir, fu_resp[gu][gl].opid, opsz);
      assign fu_claim[gu][gl] = claim[li] & ~rst;
    end
  end

  wb_collect_rr_select #(
    .nfu (nfu),
    .ewd (ewd),
    .wbw (wbw)
  ) u_rr_select (
    .req_vld  (req_vld),
    .req_sq   (req_sq),
    .rr       (rr_q),
    .en       (wb_ready),
    .claim    (claim),
    .take     (take),
    .slot     (slot),
    .any_take (any_take),
    .rr_next  (rr_next)
  );

  always_comb begin
    rr_d = rr_q;
    wb_d = wb_q;
    ix   = '0;
    sx   = '0;
    if (wb_ready) begin
      // Squashed lanes never get a slot, so the selection is already filtered.
      wb_d = '0;
      for (int i = 0; i < nl; i++) begin
        ix = iw'(i);
        if (take[ix]) wb_d[slot[ix]] = lane_flat[ix];
      end
      if (any_take) rr_d = rr_next;
    end else begin
      for (int s = 0; s < wbw; s++) begin
        sx = sw'(s);
        if (younger(redir, wb_q[sx].opid, opsz)) wb_d[sx].opid = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
      wb_q <= '0;
    end else begin
      rr_q <= rr_d;
      wb_q <= wb_d;
    end
  end

  assign wb = wb_q;

endmodule

// File: tb/tb_wb_collect.sv
module tb_wb_collect;
  import wb_collect_pkg::*;

  localparam int NFU  = 4;
  localparam int EWD  = 2;
  localparam int WBW  = 2;
  localparam int OPSZ = 64;
  localparam int NL   = NFU * EWD;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            wb_ready;
  red_bundle_t                     redir;
  exe_bundle_t [NFU-1:0][EWD-1:0]  fu_resp;
  logic        [NFU-1:0][EWD-1:0]  fu_claim;
  exe_bundle_t [WBW-1:0]           wb;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_collect #(.nfu(NFU), .ewd(EWD), .wbw(WBW), .opsz(OPSZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .redir    (redir),
    .fu_resp  (fu_resp),
    .fu_claim (fu_claim),
    .wb_ready (wb_ready),
    .wb       (wb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fixed lane contents for directed tests: lane i carries opid 2i+1.
  function automatic exe_bundle_t lane_val(input int i, input bit v);
    exe_bundle_t b;
    b.opid = 16'(2 * i + 1) | (v ? 16'h8000 : 16'h0000);
    b.data = 32'hD000_0000 | 32'(i);
    return b;
  endfunction

  task automatic set_lanes(input logic [NL-1:0] mask);
    for (int i = 0; i < NL; i++) fu_resp[i / EWD][i % EWD] = lane_val(i, mask[i]);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wb_ready = 1'b1;
    redir    = '0;
    fu_resp  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference: plain modular distance from topid, computed with signed ints.
  function automatic bit m_younger(input red_bundle_t r, input logic [15:0] id);
    int a, b;
    if (!(r.opid[15] && id[15])) return 1'b0;
    a = ((int'(id) - int'(r.topid)) % OPSZ + OPSZ) % OPSZ;
    b = ((int'(r.opid) - int'(r.topid)) % OPSZ + OPSZ) % OPSZ;
    return a >= b + 1;
  endfunction

  typedef struct {
    logic [NL-1:0] mask;
    logic [15:0]   r_op;
    logic [15:0]   r_top;
    logic [NL-1:0] exp_claim;
    logic [15:0]   exp_w0;
    logic [15:0]   exp_w1;
  } vec_t;

  vec_t vecs[$];

  // Random-test model state
  exe_bundle_t fq[NFU][$];
  int          m_rr;
  exe_bundle_t m_wb[WBW];
  bit          pend[NFU];
  bit          served[NFU];
  int          wait_cnt[NFU];
  int          max_wait;

  task automatic model_step(output logic [NL-1:0] claim_o);
    exe_bundle_t picked[$];
    int last;
    bit cut;
    claim_o = '0;
    last    = -1;
    cut     = 1'b0;
    for (int u = 0; u < NFU; u++) begin
      pend[u]   = 1'b0;
      served[u] = 1'b0;
    end
    if (!wb_ready) begin
      for (int s = 0; s < WBW; s++)
        if (m_younger(redir, m_wb[s].opid)) m_wb[s].opid = '0;
      return;
    end
    for (int k = 0; k < NFU; k++) begin
      int u;
      u = (m_rr + k) % NFU;
      for (int l = 0; l < EWD; l++) begin
        if (l >= fq[u].size()) break;
        if (m_younger(redir, fq[u][l].opid)) begin
          claim_o[u * EWD + l] = 1'b1;
          continue;
        end
        pend[u] = 1'b1;
        if (picked.size() < WBW) begin
          picked.push_back(fq[u][l]);
          claim_o[u * EWD + l] = 1'b1;
          served[u] = 1'b1;
          last = u;
          cut  = 1'b0;
        end else begin
          if (last == u) cut = 1'b1;
          break;
        end
      end
    end
    for (int s = 0; s < WBW; s++) m_wb[s] = (s < picked.size()) ? picked[s] : '0;
    if (last >= 0) m_rr = cut ? last : (last + 1) % NFU;
  endtask

  initial begin
    logic [NL-1:0] ec;
    exe_bundle_t   h0, h1;

    // mask, redir opid, redir topid, claim, wb0 opid, wb1 opid
    vecs.push_back('{8'hFF, 16'h0000, 16'h0000, 8'h03, 16'h8001, 16'h8003});
    vecs.push_back('{8'h31, 16'h0000, 16'h0000, 8'h11, 16'h8001, 16'h8009});
    vecs.push_back('{8'h04, 16'h0000, 16'h0000, 8'h04, 16'h8005, 16'h0000});
    vecs.push_back('{8'h00, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000});
    vecs.push_back('{8'hFF, 16'h8005, 16'h8000, 8'hF3, 16'h8001, 16'h8003});
    vecs.push_back('{8'hAA, 16'h0000, 16'h0000, 8'h00, 16'h0000, 16'h0000});
    vecs.push_back('{8'hFC, 16'h8005, 16'h8000, 8'hFC, 16'h8005, 16'h0000});
    vecs.push_back('{8'h0D, 16'h0000, 16'h0000, 8'h05, 16'h8001, 16'h8005});
    vecs.push_back('{8'hF0, 16'h8000, 16'h8000, 8'hF0, 16'h0000, 16'h0000});
    vecs.push_back('{8'h0F, 16'h0005, 16'h8000, 8'h03, 16'h8001, 16'h8003});
    vecs.push_back('{8'h03, 16'h8002, 16'h803C, 8'h03, 16'h8001, 16'h0000});

    rst = 1'b1; wb_ready = 1'b1; redir = '0; fu_resp = '0;

    // Table vectors, each from a fresh reset (rr = 0)
    for (int v = 0; v < vecs.size(); v++) begin
      do_reset();
      set_lanes(vecs[v].mask);
      redir = '{opid: vecs[v].r_op, topid: vecs[v].r_top};
      #1;
      check($sformatf("vec%0d_claim", v), fu_claim, vecs[v].exp_claim);
      tick();
      check($sformatf("vec%0d_wb0", v), wb[0].opid, vecs[v].exp_w0);
      check($sformatf("vec%0d_wb1", v), wb[1].opid, vecs[v].exp_w1);
    end

    // Reset mid-traffic
    do_reset();
    set_lanes('1);
    tick();
    rst = 1'b1;
    #1;
    check("rst_claim", fu_claim, 0);
    tick();
    check("rst_wb", wb, 0);
    rst = 1'b0;
    #1;
    check("rst_rr0_claim", fu_claim, 8'h03);

    // Full load rotation across units
    do_reset();
    set_lanes('1);
    for (int c = 0; c < 5; c++) begin
      int u;
      u = c % NFU;
      #1;
      check($sformatf("rot%0d_claim", c), fu_claim, 8'h03 << (2 * u));
      tick();
      check($sformatf("rot%0d_wb0", c), wb[0].opid, 16'h8000 | 16'(4 * u + 1));
      check($sformatf("rot%0d_wb1", c), wb[1].opid, 16'h8000 | 16'(4 * u + 3));
    end

    // Cut-off unit resumes first
    do_reset();
    set_lanes(8'h31);
    #1;
    check("cut_claim0", fu_claim, 8'h11);
    tick();
    check("cut_wb1", wb[1].opid, 16'h8009);
    fu_resp = '0;
    fu_resp[0][0] = '{opid: 16'h8021, data: 32'h1};
    fu_resp[2][0] = lane_val(5, 1'b1);
    fu_resp[3][0] = '{opid: 16'h8031, data: 32'h3};
    #1;
    check("cut_claim1", fu_claim, 8'h50);
    tick();
    check("cut_wb0b", wb[0].opid, 16'h800B);
    check("cut_wb1b", wb[1].opid, 16'h8031);

    // Redirect in selection cycle: squashed lane drained, survivor compacted
    do_reset();
    fu_resp[1][0] = '{opid: 16'h8007, data: 32'hA7};
    fu_resp[1][1] = '{opid: 16'h8003, data: 32'hA3};
    redir = '{opid: 16'h8005, topid: 16'h8000};
    #1;
    check("sq_claim", fu_claim, 8'h0C);
    tick();
    check("sq_wb0", wb[0], {16'h8003, 32'hA3});
    check("sq_wb1", wb[1].opid, 0);

    // Stall with in-place squash of held wb
    do_reset();
    set_lanes('1);
    tick();
    h0 = lane_val(0, 1'b1);
    h1 = lane_val(1, 1'b1);
    wb_ready = 1'b0;
    #1;
    check("stall1_claim", fu_claim, 0);
    tick();
    check("stall1_wb", wb, {h1, h0});
    redir = '{opid: 16'h8001, topid: 16'h8000};
    #1;
    check("stall2_claim", fu_claim, 0);
    tick();
    check("stall2_wb0", wb[0], h0);
    check("stall2_wb1", wb[1].opid, 0);
    redir = '0;
    #1;
    check("stall3_claim", fu_claim, 0);
    tick();
    check("stall3_wb0", wb[0], h0);
    wb_ready = 1'b1;
    #1;
    check("stall_resume_claim", fu_claim, 8'h0C);

    // Random traffic against the model
    do_reset();
    m_rr = 0;
    max_wait = 0;
    for (int s = 0; s < WBW; s++) m_wb[s] = '0;
    for (int u = 0; u < NFU; u++) begin
      fq[u].delete();
      wait_cnt[u] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int u = 0; u < NFU; u++) begin
        int n;
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          if (fq[u].size() < 5) begin
            exe_bundle_t b;
            b.opid = {1'b1, 15'($urandom)};
            b.data = $urandom;
            fq[u].push_back(b);
          end
        end
      end
      for (int u = 0; u < NFU; u++)
        for (int l = 0; l < EWD; l++)
          fu_resp[u][l] = (l < fq[u].size()) ? fq[u][l] : '0;
      if ($urandom_range(0, 3) == 0)
        redir = '{opid: {1'b1, 15'($urandom)}, topid: {1'b1, 15'($urandom)}};
      else
        redir = '0;
      wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_step(ec);
      check("rnd_claim", fu_claim, ec);
      if (wb_ready) begin
        for (int u = 0; u < NFU; u++) begin
          wait_cnt[u] = (pend[u] && !served[u]) ? wait_cnt[u] + 1 : 0;
          if (wait_cnt[u] > max_wait) max_wait = wait_cnt[u];
        end
      end
      tick();
      check("rnd_wb0", wb[0], m_wb[0]);
      check("rnd_wb1", wb[1], m_wb[1]);
      for (int u = 0; u < NFU; u++)
        for (int l = 0; l < EWD; l++)
          if (ec[u * EWD + l]) void'(fq[u].pop_front());
    end
    check("rnd_max_wait_ok", max_wait <= NFU, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
